bypass_wire_arbiter: RTL and testbench



---
 rtl/bypass_arb_pkg.sv | 22 ++
 rtl/rr_priority_pick.sv | 21 ++
 rtl/bypass_wire_arbiter.sv | 77 +++++++
 tb/tb_bypass_wire_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bypass_arb_pkg.sv
// bypass_arb_pkg: shared types and helpers for the bypass wire arbiters
package bypass_arb_pkg;
  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_t;
  localparam int MAX_REQ = 16;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int bcnt_w(input int m);
    return $clog2(m + 1);
  endfunction
  // first set bit of req scanning ptr, ptr+1, ..., wrapping at n; returns ptr when req is empty
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req, input int n, input logic [3:0] ptr);
    logic [3:0] w;
    logic [3:0] j;
    w = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      j = 4'((int'(ptr) + k) % n);
      if (req[j]) w = j;
    end
    return w;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotating-priority one-hot pick starting at ptr
module rr_priority_pick
  import bypass_arb_pkg::*;
#(
  parameter int nreq = 4,
  localparam int iw = idx_w(nreq)
) (
  input  logic [nreq-1:0] req,
  input  logic [iw-1:0]   ptr,
  output logic [nreq-1:0] gnt,
  output logic [iw-1:0]   win
);
  logic [MAX_REQ-1:0] req_x;
  // widen the request vector, pick the winner and encode it one-hot
  always_comb begin
    req_x = '0;
    req_x[nreq-1:0] = req;
    win = iw'(rr_pick(req_x, nreq, 4'(ptr)));
    gnt = |req ? nreq'(1) << win : '0;
  end
endmodule

// File: rtl/bypass_wire_arbiter.sv
// bypass_wire_arbiter: round-robin arbiter with burst lock driving one registered bypass wire
module bypass_wire_arbiter
  import bypass_arb_pkg::*;
#(
  parameter int width    = 8,
  parameter int nreq     = 4,
  parameter int maxBurst = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [nreq-1:0]       REQ,
  input  logic [nreq-1:0]       LOCK,
  input  logic [nreq*width-1:0] DIN,
  output logic [nreq-1:0]       GNT,
  output logic [width-1:0]      WVAL,
  output logic                  WHAS
);
  localparam int iw = idx_w(nreq);
  localparam int bw = bcnt_w(maxBurst);
  arb_state_t state, state_n;
  logic [iw-1:0] owner, owner_n, ptr, ptr_n, win, sel, nxt;
  logic [bw-1:0] bcnt, bcnt_n, bcnt_inc;
  logic [nreq-1:0] pick_gnt;
  logic [width-1:0] din_a [nreq];
  logic xfer;
  rr_priority_pick #(.nreq(nreq)) u_pick (
    .req(REQ),
    .ptr(ptr),
    .gnt(pick_gnt),
    .win(win)
  );
  // split the flat data bus into per-requester slices
  always_comb begin
    for (int i = 0; i < nreq; i++) din_a[i] = DIN[i*width +: width];
  end
  // grant selection and next-state logic; the owner keeps the channel until it drops, unlocks or hits the burst cap
  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    bcnt_n = bcnt;
    sel = state == OWNED ? owner : win;
    GNT = state == OWNED ? {nreq{REQ[owner]}} & (nreq'(1) << owner) : pick_gnt;
    xfer = |GNT;
    nxt = sel == iw'(nreq - 1) ? '0 : sel + 1'b1;
    bcnt_inc = bcnt + 1'b1;
    if (state == IDLE) begin
      if (xfer && LOCK[win] && maxBurst > 1) begin
        state_n = OWNED;
        owner_n = win;
        bcnt_n = bw'(1);
      end else if (xfer) ptr_n = nxt;
    end else if (!REQ[owner] || !LOCK[owner] || bcnt_inc == bw'(maxBurst)) begin
      state_n = IDLE;
      ptr_n = nxt;
      bcnt_n = '0;
    end else bcnt_n = bcnt_inc;
  end
  // state, counters and the registered wire; WVAL holds across idle cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      bcnt <= '0;
      WVAL <= '0;
      WHAS <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      bcnt <= bcnt_n;
      WHAS <= xfer;
      if (xfer) WVAL <= din_a[sel];
    end
  end
endmodule

// File: tb/tb_bypass_wire_arbiter.sv
// tb_bypass_wire_arbiter: scoreboard bench for bypass_wire_arbiter with nreq=4, maxBurst=8
module tb_bypass_wire_arbiter;
  localparam int MB = 8;
  logic CLK = 1'b0;
  logic RST;
  logic [3:0] REQ, LOCK, GNT;
  logic [31:0] DIN;
  logic [7:0] WVAL;
  logic WHAS;
  logic [7:0] din_a [4];
  logic [8:0] sb [$];
  int checks = 0;
  int errors = 0;
  bit m_init = 0;
  bit m_owned;
  int m_owner, m_ptr, m_bcnt;
  logic [7:0] m_wval;
  bit fixed_din = 0;
  bypass_wire_arbiter #(.width(8), .nreq(4), .maxBurst(MB)) dut (
    .CLK(CLK),
    .RST(RST),
    .REQ(REQ),
    .LOCK(LOCK),
    .DIN(DIN),
    .GNT(GNT),
    .WVAL(WVAL),
    .WHAS(WHAS)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic step(input logic [3:0] req, input logic [3:0] lock, input logic rst);
    logic [3:0] eg;
    logic [1:0] wi;
    logic [8:0] e;
    int w;
    if (!fixed_din) for (int i = 0; i < 4; i++) din_a[i] = 8'($urandom);
    DIN = {din_a[3], din_a[2], din_a[1], din_a[0]};
    REQ = req;
    LOCK = lock;
    RST = rst;
    #1;
    w = -1;
    if (m_owned) begin
      if (req[2'(m_owner)]) w = m_owner;
    end else begin
      for (int k = 0; k < 4; k++)
        if (w < 0 && req[2'((m_ptr + k) % 4)]) w = (m_ptr + k) % 4;
    end
    eg = '0;
    wi = 2'(w);
    if (w >= 0) eg[wi] = 1'b1;
    if (m_init) chk("gnt", 32'(GNT), 32'(eg));
    if (rst) begin
      m_init = 1;
      m_owned = 0;
      m_owner = 0;
      m_ptr = 0;
      m_bcnt = 0;
      m_wval = '0;
      e = 9'h0;
    end else begin
      if (w >= 0) m_wval = din_a[wi];
      e = {w >= 0, m_wval};
      if (m_owned) begin
        if (w < 0 || !lock[wi] || m_bcnt + 1 == MB) begin
          m_owned = 0;
          m_ptr = (m_owner + 1) % 4;
          m_bcnt = 0;
        end else m_bcnt++;
      end else if (w >= 0) begin
        if (lock[wi]) begin
          m_owned = 1;
          m_owner = w;
          m_bcnt = 1;
        end else m_ptr = (w + 1) % 4;
      end
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      chk("whas", 32'(WHAS), 32'(e[8]));
      chk("wval", 32'(WVAL), 32'(e[7:0]));
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1);
  end
  initial begin
    int g0;
    RST = 1'b1;
    REQ = '0;
    LOCK = '0;
    DIN = '0;
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    repeat (5) step(4'b0000, 4'b0000, 1'b0);
    chk("idle_gnt", 32'(GNT), 32'd0);
    chk("idle_wval", 32'(WVAL), 32'd0);
    fixed_din = 1;
    din_a[0] = 8'hA0;
    din_a[1] = 8'hA1;
    din_a[2] = 8'hA2;
    din_a[3] = 8'hA3;
    repeat (5) step(4'b1111, 4'b0000, 1'b0);
    chk("rr_last_wval", 32'(WVAL), 32'hA0);
    fixed_din = 0;
    step(4'b0000, 4'b0000, 1'b1);
    g0 = 0;
    for (int c = 0; c < 8; c++) begin
      step(4'b0011, 4'b0001, 1'b0);
      if (m_owned || c == 7) g0++;
    end
    chk("burst_len", 32'(g0), 32'd8);
    repeat (4) step(4'b0011, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    repeat (3) step(4'b0100, 4'b0100, 1'b0);
    step(4'b1000, 4'b0100, 1'b0);
    chk("bubble_whas", 32'(WHAS), 32'd0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    repeat (4) step(4'b0010, 4'b0010, 1'b0);
    step(4'b0010, 4'b0010, 1'b1);
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1001, 4'b0000, 1'b0);
    for (int c = 0; c < 80; c++)
      step(4'($urandom), 4'($urandom), $urandom_range(0, 24) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
